ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/ifetch.sv | 83 ++++++++
 tb/tb_ifetch.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package ifetch_pkg;

  localparam int          IFETCH_ADDR_W   = 15;
  localparam int unsigned IFETCH_RESET_PC = 0;

  typedef struct packed {
    logic [IFETCH_ADDR_W-1:0] pc;
    logic [31:0]              instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush, simultaneous push/pop and a
// registered head so decode sees stable, glitch-free outputs.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  output logic                     head_valid,
  output fetch_entry_t             head_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t      mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_nxt;
  logic [PW:0]       count_nxt;
  logic              do_push;
  logic              do_pop;

  assign do_push   = push && (count != (PW+1)'(DEPTH));
  assign do_pop    = pop && (count != '0);
  assign rd_nxt    = rd_ptr + PW'(do_pop);
  assign count_nxt = count + (PW+1)'(do_push) - (PW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (reset_n && !flush && do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // When the buffer drains to the entry being pushed, the head must bypass storage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_entry <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      rd_ptr     <= rd_nxt;
      wr_ptr     <= wr_ptr + PW'(do_push);
      count      <= count_nxt;
      head_valid <= (count_nxt != '0);
      if (count_nxt != '0) begin
        head_entry <= (count == {{PW{1'b0}}, do_pop}) ? push_entry : mem[rd_nxt];
      end
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: sequential PC, single-cycle memory requests gated by
// buffer credits, redirect flush, and a decode-facing instruction buffer.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int          ADDR_W     = IFETCH_ADDR_W,
  parameter int unsigned RESET_PC   = IFETCH_RESET_PC,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_read_cmd_valid,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_read_data,
  input  logic              imem_read_data_valid,
  output logic              inst_valid,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int                CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] RESET_PC_W  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] RESET_PC_AL = {RESET_PC_W[ADDR_W-1:2], 2'b00};

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              inflight;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credits_used;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  // Counting the outstanding request as used credit is what prevents overflow.
  assign credits_used        = {1'b0, fifo_count} + (CW+1)'(inflight);
  assign imem_read_cmd_valid = reset_n && fetch_en && !redirect_valid &&
                               (credits_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr           = pc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc       <= RESET_PC_AL;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_read_cmd_valid;
      if (redirect_valid) begin
        pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      end else if (imem_read_cmd_valid) begin
        pc     <= pc + ADDR_W'(4);
        req_pc <= pc;
      end
    end
  end

  assign push             = imem_read_data_valid && !redirect_valid;
  assign pop              = inst_valid && inst_ready;
  assign push_entry.pc    = IFETCH_ADDR_W'(req_pc);
  assign push_entry.instr = imem_read_data;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_valid (inst_valid),
    .head_entry (head_entry),
    .count      (fifo_count)
  );

  assign inst_pc   = ADDR_W'(head_entry.pc);
  assign inst_data = head_entry.instr;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a word-equals-address memory model and a
// reference PC scoreboard checking every delivered instruction.
module tb_ifetch;

  logic        clk;
  logic        reset_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [14:0] redirect_pc;
  logic        imem_read_cmd_valid;
  logic [14:0] imem_addr;
  logic [31:0] imem_read_data;
  logic        imem_read_data_valid;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [14:0] inst_pc;
  logic        inst_ready;

  int          checks   = 0;
  int          failures = 0;
  logic [14:0] exp_pc   = '0;
  logic        hold_prev = 1'b0;
  logic [14:0] held_pc;
  logic [31:0] held_data;

  ifetch dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .fetch_en             (fetch_en),
    .redirect_valid       (redirect_valid),
    .redirect_pc          (redirect_pc),
    .imem_read_cmd_valid  (imem_read_cmd_valid),
    .imem_addr            (imem_addr),
    .imem_read_data       (imem_read_data),
    .imem_read_data_valid (imem_read_data_valid),
    .inst_valid           (inst_valid),
    .inst_data            (inst_data),
    .inst_pc              (inst_pc),
    .inst_ready           (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers every request one cycle later with data equal to the address.
  always @(posedge clk) begin
    imem_read_data_valid <= imem_read_cmd_valid;
    imem_read_data       <= 32'(imem_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then score pops and hold-stability for that cycle.
  task automatic applyStimulus(input logic rst_n, input logic fe, input logic rv,
                               input logic [14:0] rpc, input logic rdy);
    @(negedge clk);
    reset_n        = rst_n;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    #1;
    if (hold_prev) begin
      checkOutput("hold_valid", 32'(inst_valid), 32'd1);
      checkOutput("hold_pc", 32'(inst_pc), 32'(held_pc));
      checkOutput("hold_data", inst_data, held_data);
    end
    if (!rst_n) begin
      exp_pc = '0;
    end else if (rv) begin
      exp_pc = {rpc[14:2], 2'b00};
    end else if (inst_valid && rdy) begin
      checkOutput("order_pc", 32'(inst_pc), 32'(exp_pc));
      checkOutput("order_data", inst_data, 32'(exp_pc));
      exp_pc = exp_pc + 15'd4;
    end
    hold_prev = rst_n && !rv && inst_valid && !rdy;
    held_pc   = inst_pc;
    held_data = inst_data;
  endtask

  initial begin
    applyStimulus(1'b0, 1'b1, 1'b0, 15'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_inst_pc", 32'(inst_pc), 32'h0);
    checkOutput("rst_inst_data", inst_data, 32'h0);
    checkOutput("rst_cmd_valid", 32'(imem_read_cmd_valid), 32'd0);

    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("first_cmd", 32'(imem_read_cmd_valid), 32'd1);
    checkOutput("first_addr", 32'(imem_addr), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("second_addr", 32'(imem_addr), 32'h4);
    checkOutput("second_inst_valid", 32'(inst_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("third_addr", 32'(imem_addr), 32'h8);
    checkOutput("first_inst_valid", 32'(inst_valid), 32'd1);
    checkOutput("first_inst_pc", 32'(inst_pc), 32'h0);
    checkOutput("first_inst_data", inst_data, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);

    for (int s = 1; s <= 10; s++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b0);
      if (s == 2) begin
        checkOutput("stall_cmd_s2", 32'(imem_read_cmd_valid), 32'd1);
        checkOutput("stall_addr_s2", 32'(imem_addr), 32'h18);
      end
      if (s == 3) checkOutput("stall_cmd_s3", 32'(imem_read_cmd_valid), 32'd0);
      if (s == 10) begin
        checkOutput("stall_cmd_s10", 32'(imem_read_cmd_valid), 32'd0);
        checkOutput("stall_head_pc", 32'(inst_pc), 32'hC);
        checkOutput("stall_addr_s10", 32'(imem_addr), 32'h1C);
      end
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("release_cmd", 32'(imem_read_cmd_valid), 32'd0);
    checkOutput("release_pc", 32'(inst_pc), 32'hC);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("release2_cmd", 32'(imem_read_cmd_valid), 32'd1);
    checkOutput("release2_addr", 32'(imem_addr), 32'h1C);
    checkOutput("release2_pc", 32'(inst_pc), 32'h10);
    for (int r = 0; r < 4; r++) applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);

    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 15'h103, 1'b0);
    checkOutput("redirect_cmd", 32'(imem_read_cmd_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("redirect_flush_valid", 32'(inst_valid), 32'd0);
    checkOutput("redirect_cmd1", 32'(imem_read_cmd_valid), 32'd1);
    checkOutput("redirect_addr1", 32'(imem_addr), 32'h100);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("redirect_valid2", 32'(inst_valid), 32'd0);
    checkOutput("redirect_addr2", 32'(imem_addr), 32'h104);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("redirect_valid3", 32'(inst_valid), 32'd1);
    checkOutput("redirect_pc3", 32'(inst_pc), 32'h100);
    checkOutput("redirect_data3", inst_data, 32'h100);

    applyStimulus(1'b1, 1'b1, 1'b1, 15'h7FF8, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("wrap_addr_7ff8", 32'(imem_addr), 32'h7FF8);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("wrap_addr_7ffc", 32'(imem_addr), 32'h7FFC);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("wrap_addr_0", 32'(imem_addr), 32'h0);
    checkOutput("wrap_inst_pc", 32'(inst_pc), 32'h7FF8);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("wrap_inst_pc0", 32'(inst_pc), 32'h0);

    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("midrst_cmd", 32'(imem_read_cmd_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("midrst_valid", 32'(inst_valid), 32'd0);
    checkOutput("midrst_pc", 32'(inst_pc), 32'h0);
    checkOutput("midrst_data", inst_data, 32'h0);
    checkOutput("midrst_cmd1", 32'(imem_read_cmd_valid), 32'd1);
    checkOutput("midrst_addr", 32'(imem_addr), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("midrst_valid2", 32'(inst_valid), 32'd0);
    checkOutput("midrst_addr2", 32'(imem_addr), 32'h4);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("midrst_valid3", 32'(inst_valid), 32'd1);
    checkOutput("midrst_pc3", 32'(inst_pc), 32'h0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, i[0], (i == 20), 15'h222,
                    !(i >= 14 && i < 20) && (i % 3 != 1));
      if (i == 20) checkOutput("redir_pop_valid", 32'(inst_valid), 32'd1);
      if (i == 21) checkOutput("redir_pop_flush", 32'(inst_valid), 32'd0);
    end

    applyStimulus(1'b1, 1'b1, 1'b1, 15'h300, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("final_addr", 32'(imem_addr), 32'h300);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    checkOutput("final_valid", 32'(inst_valid), 32'd1);
    checkOutput("final_pc", 32'(inst_pc), 32'h300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
